// File: rtl/leaf_mem_arbiter.sv
// Three-requester arbiter for a single-port leaf SRAM: round-robin grants with burst locking,
// combinational grant/SRAM drive and a 1-cycle rvalid strobe aligned with the SRAM read latency.
module leaf_mem_arbiter #(
    parameter int DATA_WIDTH = 11,
    parameter int PATCH_SIZE = 5,
    parameter int LEAF_SIZE  = 8,
    parameter int NUM_LEAVES = 64,
    parameter int ADDR_WIDTH = $clog2(NUM_LEAVES)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [2:0]                                 req_valid,
    output logic [2:0]                                 req_ready,
    input  logic [2:0]                                 req_last,
    input  logic                                       req_web,
    input  logic [ADDR_WIDTH-1:0]                      req_addr0,
    input  logic [ADDR_WIDTH-1:0]                      req_addr1,
    input  logic [ADDR_WIDTH-1:0]                      req_addr2,
    input  logic [LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] req_wleaf,
    output logic                                       leaf_mem_csb0,
    output logic                                       leaf_mem_web0,
    output logic [ADDR_WIDTH-1:0]                      leaf_mem_addr0,
    output logic [LEAF_SIZE*PATCH_SIZE*DATA_WIDTH-1:0] leaf_mem_wleaf0,
    output logic [2:0]                                 rvalid,
    output logic                                       busy
);

    typedef enum logic {S_OPEN = 1'b0, S_LOCKED = 1'b1} state_t;

    state_t      r_state, w_next_state;
    logic [1:0]  r_owner, w_next_owner;
    logic [1:0]  r_rr_ptr, w_next_rr_ptr;
    logic [2:0]  r_rvalid;
    logic [2:0]  w_ready;
    logic [1:0]  w_win;
    logic        w_acc;
    logic        w_win_last;

    // Grant: a ready bit is only ever raised for an asserted valid, so w_ready is the accepted one-hot.
    always_comb begin
        w_ready = 3'b000;
        if (!rst) begin
            if (r_state == S_LOCKED) begin
                case (r_owner)
                    2'd0:    w_ready = {2'b00, req_valid[0]};
                    2'd1:    w_ready = {1'b0, req_valid[1], 1'b0};
                    2'd2:    w_ready = {req_valid[2], 2'b00};
                    default: w_ready = 3'b000;
                endcase
            end else begin
                case (r_rr_ptr)
                    2'd1: begin
                        if      (req_valid[1]) w_ready = 3'b010;
                        else if (req_valid[2]) w_ready = 3'b100;
                        else if (req_valid[0]) w_ready = 3'b001;
                    end
                    2'd2: begin
                        if      (req_valid[2]) w_ready = 3'b100;
                        else if (req_valid[0]) w_ready = 3'b001;
                        else if (req_valid[1]) w_ready = 3'b010;
                    end
                    default: begin
                        if      (req_valid[0]) w_ready = 3'b001;
                        else if (req_valid[1]) w_ready = 3'b010;
                        else if (req_valid[2]) w_ready = 3'b100;
                    end
                endcase
            end
        end
    end

    assign req_ready  = w_ready;
    assign w_acc      = |w_ready;
    assign w_win      = w_ready[2] ? 2'd2 : (w_ready[1] ? 2'd1 : 2'd0);
    assign w_win_last = w_ready[2] ? req_last[2] : (w_ready[1] ? req_last[1] : req_last[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_OPEN;
            r_owner  <= 2'd0;
            r_rr_ptr <= 2'd0;
        end else begin
            r_state  <= w_next_state;
            r_owner  <= w_next_owner;
            r_rr_ptr <= w_next_rr_ptr;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_next_owner  = r_owner;
        w_next_rr_ptr = r_rr_ptr;
        if (w_acc) begin
            if (w_win_last) begin
                w_next_state  = S_OPEN;
                w_next_rr_ptr = (w_win == 2'd2) ? 2'd0 : w_win + 2'd1;
            end else if (r_state == S_OPEN) begin
                w_next_state = S_LOCKED;
                w_next_owner = w_win;
            end
        end
    end

    always_comb begin
        leaf_mem_csb0   = 1'b1;
        leaf_mem_web0   = 1'b1;
        leaf_mem_addr0  = '0;
        leaf_mem_wleaf0 = '0;
        busy            = (r_state == S_LOCKED);
        if (w_acc) begin
            leaf_mem_csb0 = 1'b0;
            case (w_win)
                2'd0: begin
                    leaf_mem_web0   = req_web;
                    leaf_mem_addr0  = req_addr0;
                    leaf_mem_wleaf0 = req_wleaf;
                end
                2'd1:    leaf_mem_addr0 = req_addr1;
                default: leaf_mem_addr0 = req_addr2;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        r_rvalid <= 3'b000;
        else if (w_acc && leaf_mem_web0) r_rvalid <= w_ready;
        else                            r_rvalid <= 3'b000;
    end

    assign rvalid = r_rvalid;

endmodule

// File: tb/tb_leaf_mem_arbiter.sv
// Randomized and directed bench for leaf_mem_arbiter against a rule-level arbitration model.
module tb_leaf_mem_arbiter;
    localparam int DW = 11, PS = 5, LS = 8, NL = 64, AW = 6, LW = LS * PS * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid, req_ready, req_last, rvalid;
    logic          req_web;
    logic [AW-1:0] a0, a1, a2, leaf_mem_addr0;
    logic [LW-1:0] req_wleaf, leaf_mem_wleaf0;
    logic          csb, web, busy;

    always #5 clk = ~clk;

    leaf_mem_arbiter #(.DATA_WIDTH(DW), .PATCH_SIZE(PS), .LEAF_SIZE(LS), .NUM_LEAVES(NL), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_last(req_last),
        .req_web(req_web), .req_addr0(a0), .req_addr1(a1), .req_addr2(a2), .req_wleaf(req_wleaf),
        .leaf_mem_csb0(csb), .leaf_mem_web0(web), .leaf_mem_addr0(leaf_mem_addr0),
        .leaf_mem_wleaf0(leaf_mem_wleaf0), .rvalid(rvalid), .busy(busy)
    );

    int errs = 0, checks = 0;

    // Model: lock flag, owning requester, next-priority requester, read strobe due this cycle.
    bit       m_locked;
    int       m_owner, m_ptr;
    logic [2:0] m_pend;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs are set before the call (away from posedge); xr >= 0 adds a directed ready check.
    task automatic step(input bit do_chk, input int xr);
        int w, i;
        bit acc, ew, lst;
        logic [2:0] er;
        logic [AW-1:0] ea;
        logic [LW-1:0] ewl;
        #1;
        acc = 0; w = 0;
        if (!rst) begin
            if (m_locked) begin
                acc = ((req_valid >> m_owner) & 3'd1) != 0;
                w = m_owner;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    i = (m_ptr + k) % 3;
                    if (!acc && (((req_valid >> i) & 3'd1) != 0)) begin
                        acc = 1; w = i;
                    end
                end
            end
        end
        er  = acc ? 3'(1 << w) : 3'b000;
        ew  = (acc && w == 0) ? req_web : 1'b1;
        ea  = !acc ? '0 : (w == 0 ? a0 : (w == 1 ? a1 : a2));
        ewl = (acc && w == 0) ? req_wleaf : '0;
        if (do_chk) begin
            chk("ready", 512'(req_ready), 512'(er));
            chk("csb", 512'(csb), 512'(!acc));
            chk("web", 512'(web), 512'(ew));
            chk("addr", 512'(leaf_mem_addr0), 512'(ea));
            chk("wleaf", 512'(leaf_mem_wleaf0), 512'(ewl));
            chk("busy", 512'(busy), 512'(m_locked));
            chk("rvalid", 512'(rvalid), 512'(m_pend));
        end
        if (xr >= 0) chk("dir_ready", 512'(req_ready), 512'(xr));
        @(posedge clk);
        if (rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_pend = 3'b000;
        end else begin
            m_pend = (acc && ew) ? er : 3'b000;
            if (acc) begin
                lst = ((req_last >> w) & 3'd1) != 0;
                if (m_locked) begin
                    if (lst) m_locked = 0;
                end else if (!lst) begin
                    m_locked = 1; m_owner = w;
                end
                if (lst) m_ptr = (w + 1) % 3;
            end
        end
        @(negedge clk);
    endtask

    logic [447:0] t;

    initial begin
        m_locked = 0; m_owner = 0; m_ptr = 0; m_pend = 3'b000;
        rst = 1; req_valid = 0; req_last = 0; req_web = 1; a0 = 0; a1 = 0; a2 = 0; req_wleaf = '0;
        @(negedge clk);
        step(0, -1);
        step(1, 0);
        rst = 0;

        // Everyone requesting single beats: strict rotation from requester 0.
        req_valid = 3'b111; req_last = 3'b111; a0 = 1; a1 = 2; a2 = 3;
        step(1, 1); step(1, 2); step(1, 4); step(1, 1);

        // Requester 1 burst of four; others keep requesting.
        for (int b = 0; b < 4; b++) begin
            a1 = AW'(10 + b);
            req_last = (b == 3) ? 3'b111 : 3'b101;
            step(1, 2);
            if (b < 3) chk("burst_busy", 512'(busy), 512'(1));
        end
        req_last = 3'b111;
        step(1, 4);

        // Loader write then port A read of the same leaf.
        req_valid = 3'b001; req_web = 0; a0 = 5; req_wleaf = LW'(44'h5a5_a5a5_a5a5);
        step(1, 1);
        req_valid = 3'b010; req_web = 1; a1 = 5;
        step(1, 2);
        req_valid = 3'b000;
        chk("wr_no_rvalid", 512'(rvalid), 512'(3'b010));
        step(1, 0);

        // Port B locks, then goes quiet for three cycles while A asks.
        req_valid = 3'b100; req_last = 3'b000; a2 = 7;
        step(1, 4);
        req_valid = 3'b010; req_last = 3'b111;
        for (int c = 0; c < 3; c++) begin
            step(1, 0);
            chk("idle_busy", 512'(busy), 512'(1));
        end
        req_valid = 3'b110; req_last = 3'b100;
        step(1, 4);

        // Reset inside a burst owned by requester 2.
        req_valid = 3'b100; req_last = 3'b000;
        step(1, 4); step(1, 4);
        rst = 1; req_valid = 3'b111;
        step(1, 0);
        rst = 0; req_last = 3'b111;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_rvalid", 512'(rvalid), 512'(0));
        step(1, 1);

        // Port A cannot write.
        req_valid = 3'b010; req_web = 0;
        step(1, 2);
        req_valid = 3'b000;
        step(1, 0);

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            req_valid = 3'($urandom);
            req_last  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            req_web   = 1'($urandom);
            a0 = AW'($urandom); a1 = AW'($urandom); a2 = AW'($urandom);
            for (int j = 0; j < 14; j++) t[j*32 +: 32] = $urandom;
            req_wleaf = t[LW-1:0];
            step(1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/leaf_mem_arbiter.md
LEAF_MEM_ARBITER -- requirements
Module: leaf_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 11, bit width of one patch element.
REQ-002 Parameter PATCH_SIZE, default 5, elements per patch.
REQ-003 Parameter LEAF_SIZE, default 8, patches per leaf word.
REQ-004 Parameter NUM_LEAVES, default 64, leaf memory depth.
REQ-005 Parameter ADDR_WIDTH, default $clog2(NUM_LEAVES), leaf address width.
REQ-006 Ports clk and rst SHALL be: one clock; reset is synchronous and active-high.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  synchronous active-high reset.
REQ-009 req_valid  in  3  per-requester access request; 0 = loader, 1 = search port A, 2 = search port B.
REQ-010 req_ready  out  3  per-requester grant; a beat is accepted when req_valid[i] and req_ready[i] are both high.
REQ-011 req_last  in  3  per-requester flag marking the final beat of a burst.
REQ-012 req_web  in  1  loader write-enable, active-low; 0 = write.
REQ-013 req_addr0/1/2  in  ADDR_WIDTH each  per-requester leaf address.
REQ-014 req_wleaf  in  LEAF_SIZE x PATCH_SIZE x DATA_WIDTH  loader write data.
REQ-015 leaf_mem_csb0  out  1  SRAM chip select, active-low.
REQ-016 leaf_mem_web0  out  1  SRAM write-enable, active-low.
REQ-017 leaf_mem_addr0  out  ADDR_WIDTH  SRAM address.
REQ-018 leaf_mem_wleaf0  out  LEAF_SIZE x PATCH_SIZE x DATA_WIDTH  SRAM write data.
REQ-019 rvalid  out  3  per-requester read-data-valid strobe.
REQ-020 busy  out  1  high when a burst lock is held.

Function
REQ-021 The block SHALL be a two-state FSM: OPEN (no owner) and LOCKED (owner register holds 0..2).
REQ-022 In OPEN, at most one ready bit SHALL be high: the first asserted req_valid in round-robin order starting from the pointer rr_ptr, wrapping 2 -> 0.
REQ-023 req_ready SHALL be combinational from req_valid, state, owner and rr_ptr, with zero-cycle grant latency.
REQ-024 An accepted beat with req_last=0 in OPEN SHALL move the FSM to LOCKED with owner = winner.
REQ-025 An accepted beat with req_last=1 in OPEN SHALL keep the FSM in OPEN.
REQ-026 In LOCKED, only req_ready[owner] SHALL be high, and only while req_valid[owner] is high.
REQ-027 If the owner drops req_valid while LOCKED, the port SHALL idle and the lock SHALL be retained.
REQ-028 An accepted beat with req_last=1 in LOCKED SHALL return the FSM to OPEN.
REQ-029 rr_ptr SHALL update to (winner+1) mod 3 on every accepted beat with req_last=1; it SHALL be unchanged otherwise.
REQ-030 On an accepted beat, leaf_mem_csb0=0 and leaf_mem_addr0 SHALL equal the winner's address, in the same cycle.
REQ-031 On a loader beat, leaf_mem_web0 SHALL equal req_web and leaf_mem_wleaf0 SHALL equal req_wleaf.
REQ-032 On a search-port beat, leaf_mem_web0 SHALL be forced to 1 and leaf_mem_wleaf0 SHALL be 0.
REQ-033 With no accepted beat, csb0=1, web0=1, addr0=0 and wleaf0=0.
REQ-034 rvalid[i] SHALL pulse high exactly one cycle after an accepted read beat (web0=1) from requester i, matching the 1-cycle SRAM read latency.
REQ-035 Write beats SHALL produce no rvalid pulse.
REQ-036 Back-to-back accepted reads SHALL produce consecutive rvalid pulses, one per beat, in acceptance order.
REQ-037 busy SHALL be high exactly when the FSM is in LOCKED.

Reset
REQ-038 While rst is high at a clock edge, the block SHALL set FSM=OPEN, owner=0, rr_ptr=0 and rvalid=0.
REQ-039 req_ready SHALL be low whenever rst is asserted.
REQ-040 SRAM outputs SHALL take their idle values (REQ-033) whenever rst is asserted.
REQ-041 Reset mid-burst SHALL drop the lock.
REQ-042 Reset SHALL suppress any rvalid pending from the pre-reset cycle.
REQ-043 The first post-reset grant SHALL follow round-robin from requester 0.

Verification
REQ-044 All three req_valid high, last=1, after reset -> grants 0,1,2,0 on consecutive cycles; rvalid follows each grant by one cycle (the loader with req_web=1).
REQ-045 Requester 1 issues a 4-beat burst (addr 10..13, last on beat 4) while requesters 0 and 2 are requesting -> ready only to 1 for 4 cycles, busy high for beats 1-3, then the next grant goes to 2.
REQ-046 Loader writes addr 5 with req_web=0, then port A reads addr 5 -> write cycle has csb0=0, web0=0 and no rvalid; read cycle has web0=1, and rvalid[1] is high the next cycle.
REQ-047 Port B deasserts valid for 3 cycles mid-burst while port A requests -> csb0=1 for those cycles, no grant to A, busy stays 1.
REQ-048 rst pulsed during a locked burst owned by 2 -> next cycle busy=0, rvalid=0, and with all requesting the grant goes to 0.
REQ-049 Port A asserts req_web=0 -> web0 stays 1 and rvalid[1] pulses.
